// File: rtl/encoder_bank.sv
// encoder_bank: multi-channel quadrature encoder front end.
// Per channel: 2-flop synchroniser, debouncer, quadrature decoder with
// illegal-transition rejection, edges-per-step divider, windowed velocity
// acceleration and a saturating signed accumulator. A shared addressed
// read-and-clear port returns one channel per request.
module encoder_bank #(
    parameter int NUM_CH         = 4,
    parameter int WIDTH          = 16,
    parameter int DEBOUNCE_BITS  = 11,
    parameter int WINDOW_BITS    = 20,
    parameter int VELOCITY_SHIFT = 3,
    parameter int STEP_DIV       = 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        re,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel,
    input  logic [NUM_CH-1:0]                           a,
    input  logic [NUM_CH-1:0]                           b,
    output logic signed [WIDTH-1:0]                     q,
    output logic                                        q_valid,
    output logic [NUM_CH-1:0]                           moved
);

    localparam int SUB_W = 4;
    localparam int EXT_W = WIDTH + VELOCITY_SHIFT + 1;

    localparam logic [DEBOUNCE_BITS-1:0]      CNT_MAX  = {DEBOUNCE_BITS{1'b1}};
    localparam logic [DEBOUNCE_BITS-1:0]      CNT_ONE  = DEBOUNCE_BITS'(1);
    localparam logic signed [SUB_W-1:0]       SUB_ONE  = SUB_W'(1);
    localparam logic signed [SUB_W-1:0]       DIV_P    = SUB_W'(STEP_DIV);
    localparam logic signed [SUB_W-1:0]       DIV_N    = -DIV_P;
    localparam logic [WIDTH-1:0]              VMAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [EXT_W-1:0]              VMAX_EXT = {{(VELOCITY_SHIFT+1){1'b0}}, VMAX};
    localparam logic [EXT_W-1:0]              EXT_ONE  = EXT_W'(1);
    localparam logic [WIDTH-1:0]              PULSE_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]              ONE_W    = WIDTH'(1);
    localparam logic signed [WIDTH:0]         ACC_MAX  = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0]         ACC_MIN  = {2'b11, {(WIDTH-1){1'b0}}};

    // Classify one debounced {A,B} transition: 2'b10 forward, 2'b01 reverse.
    function automatic logic [1:0] quad_dir(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] dir;
        case ({prev, cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dir = 2'b10;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: dir = 2'b01;
            default:                                dir = 2'b00;
        endcase
        return dir;
    endfunction

    logic [NUM_CH-1:0]             a_meta_r, a_sync_r, b_meta_r, b_sync_r;
    logic [DEBOUNCE_BITS-1:0]      a_cnt_r [NUM_CH];
    logic [DEBOUNCE_BITS-1:0]      b_cnt_r [NUM_CH];
    logic [NUM_CH-1:0]             a_deb_r, b_deb_r;
    logic [1:0]                    prev_ab_r [NUM_CH];
    logic [NUM_CH-1:0]             edge_up_r, edge_dn_r;
    logic signed [SUB_W-1:0]       sub_r [NUM_CH];
    logic [NUM_CH-1:0]             step_up_r, step_dn_r;
    logic [WINDOW_BITS-1:0]        timer_r;
    logic [WIDTH-1:0]              pulse_r [NUM_CH];
    logic [WIDTH-1:0]              vel_r [NUM_CH];
    logic signed [WIDTH-1:0]       value_r [NUM_CH];
    logic [NUM_CH-1:0]             moved_r;
    logic signed [WIDTH-1:0]       q_r;
    logic                          q_valid_r;

    logic signed [SUB_W-1:0]       sub_sum_s [NUM_CH];
    logic signed [SUB_W-1:0]       sub_nxt_s [NUM_CH];
    logic [NUM_CH-1:0]             step_up_s, step_dn_s;
    logic                          window_end_s;
    logic [31:0]                   sel_ext_s;
    logic [NUM_CH-1:0]             rd_hit_s;
    logic signed [WIDTH-1:0]       rd_val_s;
    logic signed [WIDTH-1:0]       base_s [NUM_CH];
    logic signed [WIDTH:0]         sum_s [NUM_CH];
    logic signed [WIDTH-1:0]       value_nxt_s [NUM_CH];
    logic [NUM_CH-1:0]             moved_nxt_s;
    logic [EXT_W-1:0]              ext_s [NUM_CH];
    logic [WIDTH-1:0]              vel_nxt_s [NUM_CH];
    logic [WIDTH-1:0]              pulse_nxt_s [NUM_CH];

    assign window_end_s = (timer_r == {WINDOW_BITS{1'b1}});
    assign sel_ext_s    = 32'(sel);

    // Two-flop synchronisers on every encoder pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_meta_r <= '0;
            a_sync_r <= '0;
            b_meta_r <= '0;
            b_sync_r <= '0;
        end else begin
            a_meta_r <= a;
            a_sync_r <= a_meta_r;
            b_meta_r <= b;
            b_sync_r <= b_meta_r;
        end
    end

    // Debounce: a pin must differ from its debounced level for 2^DEBOUNCE_BITS edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_deb_r <= '0;
            b_deb_r <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                a_cnt_r[ch] <= '0;
                b_cnt_r[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (a_sync_r[ch] == a_deb_r[ch]) begin
                    a_cnt_r[ch] <= '0;
                end else if (a_cnt_r[ch] == CNT_MAX) begin
                    a_deb_r[ch] <= a_sync_r[ch];
                    a_cnt_r[ch] <= '0;
                end else begin
                    a_cnt_r[ch] <= a_cnt_r[ch] + CNT_ONE;
                end
                if (b_sync_r[ch] == b_deb_r[ch]) begin
                    b_cnt_r[ch] <= '0;
                end else if (b_cnt_r[ch] == CNT_MAX) begin
                    b_deb_r[ch] <= b_sync_r[ch];
                    b_cnt_r[ch] <= '0;
                end else begin
                    b_cnt_r[ch] <= b_cnt_r[ch] + CNT_ONE;
                end
            end
        end
    end

    // Quadrature decode; the previous state follows every change, legal or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_up_r <= '0;
            edge_dn_r <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                prev_ab_r[ch] <= 2'b00;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                prev_ab_r[ch] <= {a_deb_r[ch], b_deb_r[ch]};
                {edge_up_r[ch], edge_dn_r[ch]} <= quad_dir(prev_ab_r[ch], {a_deb_r[ch], b_deb_r[ch]});
            end
        end
    end

    // Edges-per-step divider: count edges until +/-STEP_DIV, then emit a step.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sub_sum_s[ch] = sub_r[ch];
            sub_nxt_s[ch] = sub_r[ch];
            step_up_s[ch] = 1'b0;
            step_dn_s[ch] = 1'b0;
            if (edge_up_r[ch]) begin
                sub_sum_s[ch] = sub_r[ch] + SUB_ONE;
            end else if (edge_dn_r[ch]) begin
                sub_sum_s[ch] = sub_r[ch] - SUB_ONE;
            end else begin
                sub_sum_s[ch] = sub_r[ch];
            end
            if (sub_sum_s[ch] == DIV_P) begin
                step_up_s[ch] = 1'b1;
                sub_nxt_s[ch] = '0;
            end else if (sub_sum_s[ch] == DIV_N) begin
                step_dn_s[ch] = 1'b1;
                sub_nxt_s[ch] = '0;
            end else begin
                sub_nxt_s[ch] = sub_sum_s[ch];
            end
        end
    end

    // Register the sub-step counters and the step strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_up_r <= '0;
            step_dn_r <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sub_r[ch] <= '0;
            end
        end else begin
            step_up_r <= step_up_s;
            step_dn_r <= step_dn_s;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sub_r[ch] <= sub_nxt_s[ch];
            end
        end
    end

    // Shared free-running velocity window timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + WINDOW_BITS'(1);
        end
    end

    // Read selection: hit vector and the value returned on q.
    always_comb begin
        rd_val_s = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rd_hit_s[ch] = re && (sel_ext_s == 32'(ch));
            if (sel_ext_s == 32'(ch)) begin
                rd_val_s = value_r[ch];
            end else begin
                rd_val_s = rd_val_s;
            end
        end
    end

    // Next accumulator, moved flag, pulse count and velocity per channel.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            base_s[ch] = rd_hit_s[ch] ? '0 : value_r[ch];
            if (step_up_r[ch]) begin
                sum_s[ch] = {base_s[ch][WIDTH-1], base_s[ch]} + {1'b0, vel_r[ch]};
            end else if (step_dn_r[ch]) begin
                sum_s[ch] = {base_s[ch][WIDTH-1], base_s[ch]} - {1'b0, vel_r[ch]};
            end else begin
                sum_s[ch] = {base_s[ch][WIDTH-1], base_s[ch]};
            end
            if (sum_s[ch] > ACC_MAX) begin
                value_nxt_s[ch] = ACC_MAX[WIDTH-1:0];
            end else if (sum_s[ch] < ACC_MIN) begin
                value_nxt_s[ch] = ACC_MIN[WIDTH-1:0];
            end else begin
                value_nxt_s[ch] = sum_s[ch][WIDTH-1:0];
            end

            if (step_up_r[ch] || step_dn_r[ch]) begin
                moved_nxt_s[ch] = 1'b1;
            end else if (rd_hit_s[ch]) begin
                moved_nxt_s[ch] = 1'b0;
            end else begin
                moved_nxt_s[ch] = moved_r[ch];
            end

            ext_s[ch] = ({{(VELOCITY_SHIFT+1){1'b0}}, pulse_r[ch]} << VELOCITY_SHIFT) + EXT_ONE;
            if (!window_end_s) begin
                vel_nxt_s[ch] = vel_r[ch];
            end else if (ext_s[ch] > VMAX_EXT) begin
                vel_nxt_s[ch] = VMAX;
            end else begin
                vel_nxt_s[ch] = ext_s[ch][WIDTH-1:0];
            end

            // A step on the window-end edge belongs to the next window.
            if (window_end_s) begin
                pulse_nxt_s[ch] = (step_up_r[ch] || step_dn_r[ch]) ? ONE_W : '0;
            end else if ((step_up_r[ch] || step_dn_r[ch]) && (pulse_r[ch] != PULSE_MAX)) begin
                pulse_nxt_s[ch] = pulse_r[ch] + ONE_W;
            end else begin
                pulse_nxt_s[ch] = pulse_r[ch];
            end
        end
    end

    // Register accumulators, moved flags, pulse counters and velocities.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            moved_r <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                value_r[ch] <= '0;
                pulse_r[ch] <= '0;
                vel_r[ch]   <= ONE_W;
            end
        end else begin
            moved_r <= moved_nxt_s;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                value_r[ch] <= value_nxt_s[ch];
                pulse_r[ch] <= pulse_nxt_s[ch];
                vel_r[ch]   <= vel_nxt_s[ch];
            end
        end
    end

    // Read port: capture the pre-step value and strobe q_valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r       <= '0;
            q_valid_r <= 1'b0;
        end else if (re) begin
            q_r       <= rd_val_s;
            q_valid_r <= 1'b1;
        end else begin
            q_valid_r <= 1'b0;
        end
    end

    assign q       = q_r;
    assign q_valid = q_valid_r;
    assign moved   = moved_r;

endmodule

// File: tb/tb_encoder_bank.sv
// Directed self-checking bench for encoder_bank. Three instances cover the
// base configuration, a STEP_DIV=4 / 3-channel variant and a short
// velocity window variant.
module tb_encoder_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       re;
    logic [1:0] sel;
    logic [1:0] a_m, b_m, a_v, b_v;
    logic [2:0] a_d, b_d;
    logic [7:0] q_m, q_d, q_v;
    logic       qv_m, qv_d, qv_v;
    logic [1:0] mv_m, mv_v;
    logic [2:0] mv_d;

    int checks   = 0;
    int failures = 0;
    int ecount;
    int pos_m [2];
    int pos_d [3];
    int pos_v [2];

    encoder_bank #(.NUM_CH(2), .WIDTH(8), .DEBOUNCE_BITS(2), .WINDOW_BITS(12),
                   .VELOCITY_SHIFT(1), .STEP_DIV(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .re(re), .sel(sel[0:0]), .a(a_m), .b(b_m),
        .q(q_m), .q_valid(qv_m), .moved(mv_m));

    encoder_bank #(.NUM_CH(3), .WIDTH(8), .DEBOUNCE_BITS(2), .WINDOW_BITS(12),
                   .VELOCITY_SHIFT(1), .STEP_DIV(4)) dut_d (
        .clk(clk), .rst_n(rst_n), .re(re), .sel(sel), .a(a_d), .b(b_d),
        .q(q_d), .q_valid(qv_d), .moved(mv_d));

    encoder_bank #(.NUM_CH(2), .WIDTH(8), .DEBOUNCE_BITS(2), .WINDOW_BITS(6),
                   .VELOCITY_SHIFT(1), .STEP_DIV(1)) dut_v (
        .clk(clk), .rst_n(rst_n), .re(re), .sel(sel[0:0]), .a(a_v), .b(b_v),
        .q(q_v), .q_valid(qv_v), .moved(mv_v));

    // Clock edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] gray(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go_to(input int n);
        while (ecount < n - 1) @(negedge clk);
    endtask

    task automatic move_m(input int ch, input int dir);
        pos_m[ch] += dir;
        {a_m[ch], b_m[ch]} = gray(pos_m[ch]);
    endtask

    task automatic move_d(input int ch, input int dir);
        pos_d[ch] += dir;
        {a_d[ch], b_d[ch]} = gray(pos_d[ch]);
    endtask

    task automatic move_v(input int ch, input int dir);
        pos_v[ch] += dir;
        {a_v[ch], b_v[ch]} = gray(pos_v[ch]);
    endtask

    task automatic steps_m(input int ch, input int dir, input int n);
        repeat (n) begin move_m(ch, dir); hold(10); end
    endtask

    task automatic steps_d(input int ch, input int dir, input int n);
        repeat (n) begin move_d(ch, dir); hold(10); end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        re    = 1'b0;
        hold(2);
        rst_n = 1'b1;
    endtask

    // One-cycle read; returns at the negedge after the sampling edge.
    task automatic read(input logic [1:0] s);
        re  = 1'b1;
        sel = s;
        hold(1);
        re  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; re = 1'b0; sel = 2'd0;
        a_m = 2'b00; b_m = 2'b00; a_d = 3'b000; b_d = 3'b000; a_v = 2'b00; b_v = 2'b00;
        pos_m = '{0, 0}; pos_d = '{0, 0, 0}; pos_v = '{0, 0};
        hold(2);
        check("rst_q", q_m, 8'h00);
        check("rst_qv", qv_m, 1'b0);
        check("rst_moved", mv_m, 2'b00);
        check("rst_q_d", q_d, 8'h00);
        rst_n = 1'b1;
        hold(2);

        // Basic count and reverse on ch0.
        steps_m(0, 1, 3);
        steps_m(0, -1, 5);
        check("basic_moved_pre", mv_m, 2'b01);
        read(2'd0);
        check("basic_q", q_m, 8'hFE);
        check("basic_qv", qv_m, 1'b1);
        check("basic_moved_post", mv_m, 2'b00);
        hold(1);
        check("basic_qv_drop", qv_m, 1'b0);
        check("basic_q_hold", q_m, 8'hFE);
        read(2'd0);
        check("basic_q_second", q_m, 8'h00);
        read(2'd1);
        check("basic_ch1", q_m, 8'h00);

        // Glitch rejection.
        a_m = 2'b00; b_m = 2'b00; pos_m = '{0, 0};
        do_reset();
        hold(5);
        a_m[0] = 1'b1; hold(3); a_m[0] = 1'b0;
        hold(20);
        check("glitch_moved", mv_m, 2'b00);
        read(2'd0);
        check("glitch_q", q_m, 8'h00);

        // Idle-high pins from reset, then forced illegal jumps.
        a_m = 2'b11; b_m = 2'b11; pos_m = '{2, 2};
        do_reset();
        hold(20);
        check("idle_high_moved", mv_m, 2'b00);
        a_m[0] = 1'b0; b_m[0] = 1'b0; hold(10);
        a_m[0] = 1'b1; b_m[0] = 1'b1; hold(10);
        check("illegal_moved", mv_m, 2'b00);
        move_m(0, 1); hold(10);
        read(2'd0);
        check("after_illegal_q", q_m, 8'h01);

        // Saturation on ch1.
        a_m = 2'b00; b_m = 2'b00; pos_m = '{0, 0};
        do_reset();
        steps_m(1, 1, 200);
        check("sat_moved", mv_m, 2'b10);
        read(2'd1);
        check("sat_pos_q", q_m, 8'h7F);
        steps_m(1, -1, 300);
        read(2'd1);
        check("sat_neg_q", q_m, 8'h80);

        // Step divider (STEP_DIV=4) and out-of-range read.
        a_d = 3'b000; b_d = 3'b000; pos_d = '{0, 0, 0};
        do_reset();
        steps_d(1, 1, 4);
        read(2'd1);
        check("div_ch1_q", q_d, 8'h01);
        steps_d(0, 1, 6);
        check("div_moved", mv_d, 3'b001);
        read(2'd3);
        check("oob_q", q_d, 8'h00);
        check("oob_qv", qv_d, 1'b1);
        check("oob_moved_kept", mv_d, 3'b001);
        read(2'd0);
        check("div_q", q_d, 8'h01);
        steps_d(0, -1, 2);
        check("div_back_moved", mv_d, 3'b000);
        read(2'd0);
        check("div_back_q", q_d, 8'h00);

        // Read colliding with a step on the selected channel.
        a_m = 2'b00; b_m = 2'b00; pos_m = '{0, 0};
        do_reset();
        steps_m(0, 1, 5);
        move_m(0, 1);
        hold(8);
        re = 1'b1; sel = 2'd0;
        hold(1);
        re = 1'b0;
        check("coll_q", q_m, 8'h05);
        check("coll_qv", qv_m, 1'b1);
        check("coll_moved", mv_m[0], 1'b1);
        hold(3);
        check("coll_moved_hold", mv_m, 2'b01);
        read(2'd0);
        check("coll_q_next", q_m, 8'h01);
        check("coll_moved_clr", mv_m, 2'b00);

        // Velocity with a 64-cycle window.
        a_v = 2'b00; b_v = 2'b00; pos_v = '{0, 0};
        do_reset();
        move_v(0, 1);
        go_to(11);  move_v(0, 1);
        go_to(21);  move_v(0, 1);
        go_to(71);  move_v(0, 1);
        go_to(81);  move_v(0, 1);
        go_to(100);
        read(2'd0);
        check("vel_q", q_v, 8'd17);
        go_to(120); move_v(0, 1);
        go_to(135); move_v(0, 1);
        go_to(150);
        read(2'd0);
        check("vel_window_edge_q", q_v, 8'd12);
        go_to(160); move_v(0, 1);
        go_to(175); move_v(0, 1);
        hold(3);
        re = 1'b1; sel = 2'd0;
        @(posedge clk);
        #1;
        check("pre_rst_qv", qv_v, 1'b1);
        check("pre_rst_q", q_v, 8'd5);

        // Asynchronous reset in the middle of an in-flight step.
        #2;
        rst_n = 1'b0;
        re    = 1'b0;
        #1;
        check("midrst_q", q_v, 8'h00);
        check("midrst_qv", qv_v, 1'b0);
        check("midrst_moved", mv_v, 2'b00);
        hold(2);
        rst_n = 1'b1;
        hold(15);
        read(2'd0);
        check("post_rst_vel", q_v, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
